// File: rtl/ttm4_pkg.sv
// ttm4_pkg
// Constants shared by the TTM4 fetch stage and decoder: instruction field
// bit positions, the NOP encoding, the opcode map and the fetch FSM state
// encoding.
package ttm4_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int SR_MSB = 10;
  localparam int SR_LSB = 8;
  localparam int LR_MSB = 7;
  localparam int LR_LSB = 5;

  localparam logic [15:0] NOP_INSN = 16'h0000;

  localparam logic [4:0] OPC_MOV = 5'b00001;
  localparam logic [4:0] OPC_XOR = 5'b10001;
  localparam logic [4:0] OPC_AND = 5'b10000;
  localparam logic [4:0] OPC_OR  = 5'b10010;
  localparam logic [4:0] OPC_ADD = 5'b10100;
  localparam logic [4:0] OPC_SUB = 5'b10110;
  localparam logic [4:0] OPC_CMP = 5'b10111;
  localparam logic [4:0] OPC_JMP = 5'b01100;
  localparam logic [4:0] OPC_JNC = 5'b01010;
  localparam logic [4:0] OPC_JC  = 5'b01011;
  localparam logic [4:0] OPC_JNZ = 5'b01110;
  localparam logic [4:0] OPC_JZ  = 5'b01111;
  localparam logic [4:0] OPC_PSH = 5'b01001;
  localparam logic [4:0] OPC_POP = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetchState_t;

endpackage

// File: rtl/ttm4_pc_counter.sv
// ttm4_pc_counter
// AW-bit program counter with asynchronous reset to RESET_PC, parallel load
// (priority) and increment that wraps modulo 2^AW.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   load  - load pcIn this edge
//   inc   - increment this edge (ignored when load is set)
//   pcIn  - load value
//   pc    - current program counter
module ttm4_pc_counter #(
  parameter int            AW       = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] pcIn,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pcIn;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/ttm4_instruction_fetch.sv
// ttm4_instruction_fetch
// Fetch stage feeding the TTM4 decoder. Reads program memory at PC through a
// req/ack handshake, latches the word into the instruction register and
// presents its fields for one EXEC cycle, then advances or redirects the PC.
// Ports:
//   CLK, RST            - clock, asynchronous active-high reset
//   MEM_RD, MEM_ADDR    - read request and address (held until MEM_ACK)
//   MEM_ACK, MEM_DATA   - read data valid strobe and instruction word
//   nPC_LD, PC_IN       - active-low jump request and target, used in EXEC
//   OP, SR, LR, IMM     - instruction fields taken straight from the IR
//   INSN_VALID          - fields valid (EXEC state)
//   PC                  - current program counter
//   RETIRED             - saturating executed-instruction count
//   HALT, STEP          - only with TTM4_FETCH_STEP_EN defined: hold the
//                         fetch loop, and single-step one instruction
module ttm4_instruction_fetch
  import ttm4_pkg::*;
#(
  parameter int            AW       = 4,
  parameter int            IW       = 16,
  parameter int            IMM_W    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             MEM_RD,
  output logic [AW-1:0]    MEM_ADDR,
  input  logic             MEM_ACK,
  input  logic [IW-1:0]    MEM_DATA,
  input  logic             nPC_LD,
  input  logic [AW-1:0]    PC_IN,
`ifdef TTM4_FETCH_STEP_EN
  input  logic             HALT,
  input  logic             STEP,
`endif
  output logic [4:0]       OP,
  output logic [2:0]       SR,
  output logic [2:0]       LR,
  output logic [IMM_W-1:0] IMM,
  output logic             INSN_VALID,
  output logic [AW-1:0]    PC,
  output logic [15:0]      RETIRED
);

  fetchState_t   stateQ, stateD;
  logic [IW-1:0] irQ;
  logic [15:0]   retiredQ;
  logic          memRd, insnValid, capture, pcLoad, pcInc;
  logic          fetchEn;
  logic          unusedIrBits;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef TTM4_FETCH_STEP_EN
  // Once a read has been issued it runs to its ack regardless of HALT, so
  // MEM_ADDR stays stable and a late HALT only bites after the next EXEC.
  logic readActiveQ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      readActiveQ <= 1'b0;
    end else begin
      readActiveQ <= memRd && !MEM_ACK;
    end
  end

  assign fetchEn = !HALT || STEP || readActiveQ;
`else
  assign fetchEn = 1'b1;
`endif

  // ---- state register ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    memRd     = 1'b0;
    insnValid = 1'b0;
    capture   = 1'b0;
    pcLoad    = 1'b0;
    pcInc     = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        stateD = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetchEn) begin
          memRd = 1'b1;
          if (MEM_ACK) begin
            capture = 1'b1;
            stateD  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        insnValid = 1'b1;
        stateD    = ST_FETCH;
        if (!nPC_LD) begin
          pcLoad = 1'b1;
        end else begin
          pcInc = 1'b1;
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // ---- instruction register and retire counter ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irQ      <= IW'(NOP_INSN);
      retiredQ <= 16'd0;
    end else begin
      if (capture) begin
        irQ <= MEM_DATA;
      end
      if (insnValid) begin
        retiredQ <= satInc16(retiredQ);
      end
    end
  end

  ttm4_pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) uPcCounter (
    .clk  (CLK),
    .rst  (RST),
    .load (pcLoad),
    .inc  (pcInc),
    .pcIn (PC_IN),
    .pc   (PC)
  );

  // ---- outputs ----
  assign MEM_RD     = memRd;
  assign MEM_ADDR   = PC;
  assign INSN_VALID = insnValid;
  assign RETIRED    = retiredQ;
  assign OP         = irQ[OP_MSB:OP_LSB];
  assign SR         = irQ[SR_MSB:SR_LSB];
  assign LR         = irQ[LR_MSB:LR_LSB];
  assign IMM        = irQ[IMM_W-1:0];

  // IR bits between the LR and IMM fields are not decoded.
  assign unusedIrBits = ^irQ;

endmodule

// File: tb/tb_ttm4_instruction_fetch.sv
// tb_ttm4_instruction_fetch
// Directed bench for ttm4_instruction_fetch: reset values, zero-wait fetch,
// wait-state fetch, jump/no-jump, PC wrap, reset during a pending read with a
// stale ack, and (with TTM4_FETCH_STEP_EN) halt/single-step.
module tb_ttm4_instruction_fetch;

  logic        tb_CLK = 1'b0;
  logic        RST;
  logic        MEM_RD;
  logic [3:0]  MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic        nPC_LD;
  logic [3:0]  PC_IN;
  logic [4:0]  OP;
  logic [2:0]  SR;
  logic [2:0]  LR;
  logic [3:0]  IMM;
  logic        INSN_VALID;
  logic [3:0]  PC;
  logic [15:0] RETIRED;
`ifdef TTM4_FETCH_STEP_EN
  logic        HALT;
  logic        STEP;
`endif

  logic [15:0] mem [16];
  int          checks   = 0;
  int          failures = 0;

  assign MEM_DATA = mem[MEM_ADDR];

  always #5 tb_CLK = ~tb_CLK;

  ttm4_instruction_fetch dut (
    .CLK        (tb_CLK),
    .RST        (RST),
    .MEM_RD     (MEM_RD),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_ACK    (MEM_ACK),
    .MEM_DATA   (MEM_DATA),
    .nPC_LD     (nPC_LD),
    .PC_IN      (PC_IN),
`ifdef TTM4_FETCH_STEP_EN
    .HALT       (HALT),
    .STEP       (STEP),
`endif
    .OP         (OP),
    .SR         (SR),
    .LR         (LR),
    .IMM        (IMM),
    .INSN_VALID (INSN_VALID),
    .PC         (PC),
    .RETIRED    (RETIRED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0800;  // MOV
    mem[1]  = 16'h6000;  // JMP
    mem[10] = 16'h6000;  // JMP
    mem[11] = 16'h6000;  // JMP
    mem[15] = 16'hA123;  // ADD SR=1 LR=1 IMM=3

    RST     = 1'b1;
    MEM_ACK = 1'b0;
    nPC_LD  = 1'b1;
    PC_IN   = 4'h0;
`ifdef TTM4_FETCH_STEP_EN
    HALT    = 1'b0;
    STEP    = 1'b0;
`endif
    tick();
    tick();
    chk("rst_pc",      32'(PC),         32'h0);
    chk("rst_op",      32'(OP),         32'h0);
    chk("rst_valid",   32'(INSN_VALID), 32'h0);
    chk("rst_memrd",   32'(MEM_RD),     32'h0);
    chk("rst_retired", 32'(RETIRED),    32'h0);

    // Zero-wait fetch of MOV at address 0
    RST     = 1'b0;
    MEM_ACK = 1'b1;
    tick();                                   // IDLE -> FETCH
    chk("f0_memrd",  32'(MEM_RD),   32'h1);
    chk("f0_addr",   32'(MEM_ADDR), 32'h0);
    tick();                                   // FETCH -> EXEC
    chk("f0_op",     32'(OP),         32'h01);
    chk("f0_valid",  32'(INSN_VALID), 32'h1);
    chk("f0_exmemrd", 32'(MEM_RD),    32'h0);
    MEM_ACK = 1'b0;
    tick();                                   // EXEC -> FETCH @1
    chk("f0_pc",      32'(PC),       32'h1);
    chk("f0_retired", 32'(RETIRED),  32'h1);

    // Three wait cycles at address 1
    chk("w_memrd0", 32'(MEM_RD),   32'h1);
    chk("w_addr0",  32'(MEM_ADDR), 32'h1);
    tick();
    chk("w_memrd1", 32'(MEM_RD),   32'h1);
    chk("w_addr1",  32'(MEM_ADDR), 32'h1);
    tick();
    chk("w_memrd2", 32'(MEM_RD),   32'h1);
    chk("w_addr2",  32'(MEM_ADDR), 32'h1);
    chk("w_valid2", 32'(INSN_VALID), 32'h0);
    MEM_ACK = 1'b1;
    tick();                                   // EXEC of JMP
    chk("w_valid",   32'(INSN_VALID), 32'h1);
    chk("w_op_jmp",  32'(OP),         32'h0C);
    chk("w_retired", 32'(RETIRED),    32'h1);

    // Taken jump to 4'hA
    MEM_ACK = 1'b0;
    nPC_LD  = 1'b0;
    PC_IN   = 4'hA;
    tick();
    chk("jmp_addr",    32'(MEM_ADDR), 32'hA);
    chk("jmp_retired", 32'(RETIRED),  32'h2);

    // Same JMP, no load -> PC+1
    nPC_LD  = 1'b1;
    PC_IN   = 4'h3;
    MEM_ACK = 1'b1;
    tick();
    chk("nj_valid", 32'(INSN_VALID), 32'h1);
    MEM_ACK = 1'b0;
    tick();
    chk("nj_addr", 32'(MEM_ADDR), 32'hB);

    // Jump to 4'hF, then execute ADD there and wrap to 0
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    nPC_LD  = 1'b0;
    PC_IN   = 4'hF;
    tick();
    chk("to_f_addr", 32'(MEM_ADDR), 32'hF);
    nPC_LD  = 1'b1;
    MEM_ACK = 1'b1;
    tick();
    chk("add_op",  32'(OP),  32'h14);
    chk("add_sr",  32'(SR),  32'h1);
    chk("add_lr",  32'(LR),  32'h1);
    chk("add_imm", 32'(IMM), 32'h3);
    MEM_ACK = 1'b0;
    tick();
    chk("wrap_addr",    32'(MEM_ADDR), 32'h0);
    chk("wrap_retired", 32'(RETIRED),  32'h5);
    chk("wrap_memrd",   32'(MEM_RD),   32'h1);

    // Reset during the pending read, stale ack after release
    RST = 1'b1;
    #2;
    chk("mr_pc",      32'(PC),         32'h0);
    chk("mr_op",      32'(OP),         32'h0);
    chk("mr_imm",     32'(IMM),        32'h0);
    chk("mr_valid",   32'(INSN_VALID), 32'h0);
    chk("mr_memrd",   32'(MEM_RD),     32'h0);
    chk("mr_retired", 32'(RETIRED),    32'h0);
    tick();
    RST     = 1'b0;
    MEM_ACK = 1'b1;
    tick();                                   // IDLE -> FETCH, ack ignored
    chk("st_op",    32'(OP),         32'h0);
    chk("st_valid", 32'(INSN_VALID), 32'h0);
    chk("st_addr",  32'(MEM_ADDR),   32'h0);
    chk("st_memrd", 32'(MEM_RD),     32'h1);
    MEM_ACK = 1'b0;
    tick();
    chk("st_op2",   32'(OP),         32'h0);
    MEM_ACK = 1'b1;
    tick();
    chk("nf_op",    32'(OP),         32'h01);
    chk("nf_valid", 32'(INSN_VALID), 32'h1);
    MEM_ACK = 1'b0;
    tick();
    chk("nf_pc",      32'(PC),      32'h1);
    chk("nf_retired", 32'(RETIRED), 32'h1);

`ifdef TTM4_FETCH_STEP_EN
    // Halt after the next instruction, then single-step once
    MEM_ACK = 1'b1;
    tick();                                   // EXEC @1
    HALT = 1'b1;
    tick();                                   // FETCH, halted
    chk("h_memrd0",   32'(MEM_RD),  32'h0);
    chk("h_retired0", 32'(RETIRED), 32'h2);
    tick();
    chk("h_memrd1", 32'(MEM_RD),     32'h0);
    chk("h_valid1", 32'(INSN_VALID), 32'h0);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    chk("s_valid", 32'(INSN_VALID), 32'h1);
    tick();
    chk("s_retired", 32'(RETIRED),    32'h3);
    chk("s_memrd",   32'(MEM_RD),     32'h0);
    tick();
    chk("s_memrd2",  32'(MEM_RD),     32'h0);
    chk("s_valid2",  32'(INSN_VALID), 32'h0);
    chk("s_retired2", 32'(RETIRED),   32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
